// File: rtl/reu_pkg.sv
// Shared types and constants for the REU DMA sequencer and its PHI2/BA synchroniser.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package reu_pkg;

  // Transfer modes as encoded on the Mode input.
  typedef enum logic [1:0] {
    STASH  = 2'd0,
    FETCH  = 2'd1,
    SWAP   = 2'd2,
    VERIFY = 2'd3
  } reuMode_t;

  // Sequencer states; XFER2 is only used by swap for its write phase.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    XFER2 = 3'd3,
    END   = 3'd4
  } reuState_t;

  // Flops between an asynchronous C64 signal and its first use.
  localparam int SYNC_DEPTH = 2;

  // Mode 3 is only accepted when the verify option is built in.
  function automatic logic modeLegal(input logic [1:0] m);
`ifdef REU_VERIFY_EN
    modeLegal = (m == m);
`else
    modeLegal = (m != 2'd3);
`endif
  endfunction

endpackage

// File: rtl/phi2_edge_sync.sv
// Synchronises one asynchronous C64 signal (PHI2 or BA) and produces one-CLK rise/fall pulses.
// Latency: level and edge pulses lag the real edge by 2-3 CLK.
// Backpressure: none; free-running.
module phi2_edge_sync
  import reu_pkg::*;
(
  input  logic clk,
  input  logic nRst,
  input  logic asyncIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] syncQ;
  logic                  prevQ;

  // Synchroniser chain plus one extra flop remembering the previous synchronised level.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_DEPTH-2:0], asyncIn};
      prevQ <= syncQ[SYNC_DEPTH-1];
    end
  end

  assign level = syncQ[SYNC_DEPTH-1];
  assign rise  = level & ~prevQ;
  assign fall  = ~level & prevQ;

endmodule

// File: rtl/reu_dma_sequencer.sv
// REU DMA engine: moves Len bytes between the C64 bus and expansion RAM, one byte per PHI2 cycle.
// Latency: Busy one CLK after Start; each byte completes at the synchronised PHI2 fall (2-3 CLK after the real edge).
// Backpressure: BA low at a PHI2 rise stalls the block with DMA held and counters frozen; Start while Busy is ignored.
// Build option: define REU_VERIFY_EN to enable Mode 3 (verify); otherwise Mode 3 Starts are ignored.
module reu_dma_sequencer
  import reu_pkg::*;
#(
  parameter int RA_W  = 19,
  parameter int LEN_W = 16,
  parameter int CA_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             PHI2,
  input  logic             BA,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CA_W-1:0]  CBase,
  input  logic [RA_W-1:0]  RBase,
  input  logic [LEN_W-1:0] Len,
  input  logic             CFix,
  input  logic             RFix,
  input  logic             AutoLd,
  input  logic             IrqEn,
  input  logic             IrqAck,
  input  logic [7:0]       CDin,
  input  logic [7:0]       RDin,
  output logic             DMA,
  output logic             nWEDMA,
  output logic [CA_W-1:0]  CAddr,
  output logic [RA_W-1:0]  RAddr,
  output logic [7:0]       CDout,
  output logic [7:0]       RDout,
  output logic             RRd,
  output logic             RWr,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic             IRQ
);

  localparam logic [CA_W-1:0]  C_ONE = {{(CA_W-1){1'b0}}, 1'b1};
  localparam logic [RA_W-1:0]  R_ONE = {{(RA_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] L_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  reuState_t        state, nextState;
  reuMode_t         modeQ;
  logic [CA_W-1:0]  cBaseQ;
  logic [RA_W-1:0]  rBaseQ;
  logic [LEN_W-1:0] lenBaseQ;
  logic [LEN_W-1:0] lenCnt;
  logic             cFixQ, rFixQ, autoLdQ, irqEnQ;
  logic             swapPend;   // swap read phase done, write phase due at next rise
  logic             advance;    // byte finished last CLK: step counters now

  logic phi2Level, phi2Rise, phi2Fall;
  logic baLevel, baRise, baFall;
  logic busOk, startOk, beginByte, lastByte, verifyMiss;

  phi2_edge_sync uPhi2Sync (
    .clk    (CLK),
    .nRst   (nRST),
    .asyncIn(PHI2),
    .level  (phi2Level),
    .rise   (phi2Rise),
    .fall   (phi2Fall)
  );

  phi2_edge_sync uBaSync (
    .clk    (CLK),
    .nRst   (nRST),
    .asyncIn(BA),
    .level  (baLevel),
    .rise   (baRise),
    .fall   (baFall)
  );

  // BA must be high and settled (no edge in this CLK) for a PHI2 rise to start a byte.
  assign busOk     = baLevel & ~(baRise | baFall);
  assign startOk   = Start & modeLegal(Mode);
  assign beginByte = (state == REQ) & phi2Rise & busOk;
  assign lastByte  = (lenCnt == L_ONE);
  assign Busy      = (state != IDLE);

`ifdef REU_VERIFY_EN
  assign verifyMiss = (modeQ == VERIFY) & (CDin != RDin);
`else
  assign verifyMiss = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= nextState;
  end

  // Next state and bus command outputs; C64 writes are only driven while synchronised PHI2 is high.
  always_comb begin
    nextState = state;
    DMA       = 1'b0;
    nWEDMA    = 1'b1;
    case (state)
      IDLE: begin
        if (startOk) nextState = REQ;
      end
      REQ: begin
        DMA = 1'b1;
        if (beginByte) nextState = swapPend ? XFER2 : XFER;
      end
      XFER: begin
        DMA = 1'b1;
        if (modeQ == FETCH && phi2Level) nWEDMA = 1'b0;
        if (phi2Fall) begin
          if (modeQ == SWAP)             nextState = REQ;
          else if (verifyMiss || lastByte) nextState = END;
          else                           nextState = REQ;
        end
      end
      XFER2: begin
        DMA = 1'b1;
        if (phi2Level) nWEDMA = 1'b0;
        if (phi2Fall) nextState = lastByte ? END : REQ;
      end
      END: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: field latch at Start, RAM strobes, data capture, counter stepping, status and IRQ.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      modeQ    <= STASH;
      cBaseQ   <= '0;
      rBaseQ   <= '0;
      lenBaseQ <= '0;
      cFixQ    <= 1'b0;
      rFixQ    <= 1'b0;
      autoLdQ  <= 1'b0;
      irqEnQ   <= 1'b0;
      lenCnt   <= '0;
      CAddr    <= '0;
      RAddr    <= '0;
      CDout    <= '0;
      RDout    <= '0;
      RRd      <= 1'b0;
      RWr      <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
      IRQ      <= 1'b0;
      swapPend <= 1'b0;
      advance  <= 1'b0;
    end else begin
      RRd     <= 1'b0;
      RWr     <= 1'b0;
      advance <= 1'b0;

      // Counter stepping lags the byte by one CLK so RWr still sees the byte's own address.
      // An autoload at END takes priority over the final step.
      if (state == END && autoLdQ) begin
        CAddr  <= cBaseQ;
        RAddr  <= rBaseQ;
        lenCnt <= lenBaseQ;
      end else if (advance) begin
        if (!cFixQ) CAddr <= CAddr + C_ONE;
        if (!rFixQ) RAddr <= RAddr + R_ONE;
        lenCnt <= lenCnt - L_ONE;
      end

      if (state == IDLE && startOk) begin
        modeQ    <= reuMode_t'(Mode);
        cBaseQ   <= CBase;
        rBaseQ   <= RBase;
        lenBaseQ <= Len;
        cFixQ    <= CFix;
        rFixQ    <= RFix;
        autoLdQ  <= AutoLd;
        irqEnQ   <= IrqEn;
        CAddr    <= CBase;
        RAddr    <= RBase;
        lenCnt   <= Len;
        Done     <= 1'b0;
        Fault    <= 1'b0;
        swapPend <= 1'b0;
      end

      // At the rise: swap write phase writes REU now, every reading mode strobes RAM.
      if (beginByte) begin
        if (swapPend)            RWr <= 1'b1;
        else if (modeQ != STASH) RRd <= 1'b1;
      end

      // Fetch drives C64 with the byte the RAM returned during the read strobe.
      if (state == XFER && RRd && modeQ == FETCH) CDout <= RDin;

      if (state == XFER && phi2Fall) begin
        case (modeQ)
          STASH: begin
            RDout   <= CDin;
            RWr     <= 1'b1;
            advance <= 1'b1;
          end
          FETCH: begin
            advance <= 1'b1;
          end
          SWAP: begin
            RDout    <= CDin;
            CDout    <= RDin;
            swapPend <= 1'b1;
          end
          default: begin
            // A mismatched byte still counts as transferred so counters point past it.
            if (verifyMiss) Fault <= 1'b1;
            advance <= 1'b1;
          end
        endcase
      end

      if (state == XFER2 && phi2Fall) begin
        swapPend <= 1'b0;
        advance  <= 1'b1;
      end

      if (state == END) Done <= 1'b1;

      // A new end-of-block event wins over an acknowledge in the same CLK.
      if (state == END && irqEnQ) IRQ <= 1'b1;
      else if (IrqAck)            IRQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// Directed bench for reu_dma_sequencer with C64 and REU memory models.
// Latency: n/a.
// Backpressure: BA driven directly by the stimulus.
module tb_reu_dma_sequencer;
  import reu_pkg::*;

  logic        CLK = 1'b0, nRST = 1'b0, PHI2 = 1'b0, BA = 1'b1, Start = 1'b0;
  logic [1:0]  Mode = 2'd0;
  logic [15:0] CBase = '0;
  logic [18:0] RBase = '0;
  logic [3:0]  Len = '0;
  logic        CFix = 1'b0, RFix = 1'b0, AutoLd = 1'b0, IrqEn = 1'b0, IrqAck = 1'b0;
  logic [7:0]  CDin, RDin;
  logic        DMA, nWEDMA, RRd, RWr, Busy, Done, Fault, IRQ;
  logic [15:0] CAddr;
  logic [18:0] RAddr;
  logic [7:0]  CDout, RDout;

  logic [7:0] cMem [0:65535];
  logic [7:0] rMem [0:4095];
  int rwrCount = 0, cwrCount = 0, phi2Rises = 0;
  int checks = 0, failures = 0;

  reu_dma_sequencer #(.RA_W(19), .LEN_W(4), .CA_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .PHI2(PHI2), .BA(BA), .Start(Start), .Mode(Mode),
    .CBase(CBase), .RBase(RBase), .Len(Len), .CFix(CFix), .RFix(RFix),
    .AutoLd(AutoLd), .IrqEn(IrqEn), .IrqAck(IrqAck), .CDin(CDin), .RDin(RDin),
    .DMA(DMA), .nWEDMA(nWEDMA), .CAddr(CAddr), .RAddr(RAddr), .CDout(CDout),
    .RDout(RDout), .RRd(RRd), .RWr(RWr), .Busy(Busy), .Done(Done), .Fault(Fault),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;
  // PHI2 period is not a multiple of CLK so its edges drift against the core clock.
  always #82 PHI2 = ~PHI2;

  assign CDin = cMem[CAddr];
  assign RDin = rMem[RAddr[11:0]];

  always @(posedge CLK) begin
    if (RWr) begin
      rMem[RAddr[11:0]] = RDout;
      rwrCount++;
    end
  end

  always @(negedge PHI2) begin
    if (DMA && !nWEDMA) begin
      cMem[CAddr] = CDout;
      cwrCount++;
    end
  end

  always @(posedge PHI2) phi2Rises++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic startXfer(input logic [1:0] m, input logic [15:0] cb, input logic [18:0] rb,
                           input logic [3:0] ln, input logic al, input logic ie);
    @(negedge CLK);
    Mode = m; CBase = cb; RBase = rb; Len = ln; AutoLd = al; IrqEn = ie; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      if (Done) break;
      @(negedge CLK);
    end
  endtask

  int base, cbase, rises, dmaDrops, stallStrobes;

  initial begin
    for (int i = 0; i < 65536; i++) cMem[i] = 8'h00;
    for (int i = 0; i < 4096; i++)  rMem[i] = 8'hEE;

    // Reset values
    repeat (4) @(negedge CLK);
    checkVal("rst_dma", 32'(DMA), 0);
    checkVal("rst_nwedma", 32'(nWEDMA), 1);
    checkVal("rst_strobes", 32'({RRd, RWr}), 0);
    checkVal("rst_status", 32'({Busy, Done, Fault, IRQ}), 0);
    checkVal("rst_caddr", 32'(CAddr), 0);
    checkVal("rst_raddr", 32'(RAddr), 0);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    // Stash 4 bytes C64 0x1000 -> REU 0
    for (int i = 0; i < 4; i++) cMem[16'h1000 + i] = 8'(17 * (i + 1));
    base = rwrCount;
    startXfer(STASH, 16'h1000, 19'h0, 4'd4, 1'b0, 1'b1);
    checkVal("stash_busy", 32'(Busy), 1);
    waitDone(400);
    checkVal("stash_done", 32'(Done), 1);
    checkVal("stash_rwr_cnt", 32'(rwrCount - base), 4);
    checkVal("stash_r0", 32'(rMem[0]), 'h11);
    checkVal("stash_r3", 32'(rMem[3]), 'h44);
    checkVal("stash_r4_untouched", 32'(rMem[4]), 'hEE);
    checkVal("stash_caddr", 32'(CAddr), 'h1004);
    checkVal("stash_raddr", 32'(RAddr), 'h4);
    checkVal("stash_irq", 32'(IRQ), 1);
    checkVal("stash_dma_off", 32'(DMA), 0);
    IrqAck = 1'b1;
    @(negedge CLK);
    IrqAck = 1'b0;
    checkVal("irqack_clear", 32'(IRQ), 0);
    @(negedge CLK);
    checkVal("stash_idle", 32'(Busy), 0);

    // Fetch Len=0 with LEN_W=4: 16 bytes REU 0x100 -> C64 0x2000, IrqAck held throughout
    for (int i = 0; i < 16; i++) rMem[12'h100 + i] = 8'h5A ^ 8'(i);
    cbase = cwrCount;
    IrqAck = 1'b1;
    startXfer(FETCH, 16'h2000, 19'h100, 4'd0, 1'b0, 1'b1);
    waitDone(800);
    checkVal("fetch_done", 32'(Done), 1);
    checkVal("fetch_irq_beats_ack", 32'(IRQ), 1);
    checkVal("fetch_cwr_cnt", 32'(cwrCount - cbase), 16);
    checkVal("fetch_c0", 32'(cMem[16'h2000]), 'h5A);
    checkVal("fetch_c15", 32'(cMem[16'h200F]), 'h55);
    checkVal("fetch_c16_untouched", 32'(cMem[16'h2010]), 'h00);
    checkVal("fetch_caddr", 32'(CAddr), 'h2010);
    checkVal("fetch_dma_off", 32'(DMA), 0);
    @(negedge CLK);
    checkVal("fetch_ack_clears", 32'(IRQ), 0);
    IrqAck = 1'b0;

    // Swap one byte, IRQ disabled
    cMem[16'h3000] = 8'hAA;
    rMem[12'h200]  = 8'h55;
    base = rwrCount; cbase = cwrCount;
    startXfer(SWAP, 16'h3000, 19'h200, 4'd1, 1'b0, 1'b0);
    waitDone(300);
    checkVal("swap_done", 32'(Done), 1);
    checkVal("swap_c64", 32'(cMem[16'h3000]), 'h55);
    checkVal("swap_reu", 32'(rMem[12'h200]), 'hAA);
    checkVal("swap_writes", 32'({8'(rwrCount - base), 8'(cwrCount - cbase)}), 'h0101);
    checkVal("swap_no_irq", 32'(IRQ), 0);

    // Stash 2 bytes with BA low for 3 PHI2 rises after the first byte
    cMem[16'h4000] = 8'hC1;
    cMem[16'h4001] = 8'hC2;
    base = rwrCount;
    startXfer(STASH, 16'h4000, 19'h300, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 300 && rwrCount == base; i++) @(negedge CLK);
    BA = 1'b0;
    rises = phi2Rises;
    dmaDrops = 0; stallStrobes = 0;
    for (int i = 0; i < 300 && phi2Rises < rises + 3; i++) begin
      @(negedge CLK);
      if (!DMA) dmaDrops++;
      if (RRd || RWr) stallStrobes++;
    end
    repeat (4) begin
      @(negedge CLK);
      if (!DMA) dmaDrops++;
      if (RRd || RWr) stallStrobes++;
    end
    checkVal("stall_rises", 32'(phi2Rises - rises), 3);
    checkVal("stall_dma_held", 32'(dmaDrops), 0);
    checkVal("stall_no_strobes", 32'(stallStrobes), 0);
    checkVal("stall_one_byte", 32'(rwrCount - base), 1);
    BA = 1'b1;
    waitDone(300);
    checkVal("stall_done", 32'(Done), 1);
    checkVal("stall_two_bytes", 32'(rwrCount - base), 2);
    checkVal("stall_r1", 32'(rMem[12'h301]), 'hC2);

`ifdef REU_VERIFY_EN
    // Verify 5 bytes with a mismatch at byte 2
    for (int i = 0; i < 5; i++) begin
      cMem[16'h5000 + i] = 8'h70 + 8'(i);
      rMem[12'h400 + i]  = 8'h70 + 8'(i);
    end
    rMem[12'h401] = 8'h00;
    startXfer(VERIFY, 16'h5000, 19'h400, 4'd5, 1'b0, 1'b1);
    waitDone(400);
    checkVal("verify_fault", 32'(Fault), 1);
    checkVal("verify_irq", 32'(IRQ), 1);
    checkVal("verify_len", 32'(dut.lenCnt), 3);
    checkVal("verify_caddr", 32'(CAddr), 'h5002);
    IrqAck = 1'b1;
    @(negedge CLK);
    IrqAck = 1'b0;
`else
    // Mode 3 is not legal without the verify option
    startXfer(VERIFY, 16'h5000, 19'h400, 4'd5, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    checkVal("mode3_busy", 32'(Busy), 0);
    checkVal("mode3_dma", 32'(DMA), 0);
    checkVal("mode3_fault", 32'(Fault), 0);
`endif

    // Autoload stash: counters return to the bases at the end of the block
    for (int i = 0; i < 3; i++) cMem[16'h6000 + i] = 8'hB0 + 8'(i);
    startXfer(STASH, 16'h6000, 19'h500, 4'd3, 1'b1, 1'b0);
    waitDone(400);
    checkVal("autold_done", 32'(Done), 1);
    checkVal("autold_fault_clear", 32'(Fault), 0);
    checkVal("autold_caddr", 32'(CAddr), 'h6000);
    checkVal("autold_raddr", 32'(RAddr), 'h500);
    checkVal("autold_len", 32'(dut.lenCnt), 3);
    checkVal("autold_r2", 32'(rMem[12'h502]), 'hB2);

    // Reset in the middle of a fetch
    startXfer(FETCH, 16'h7000, 19'h600, 4'd8, 1'b0, 1'b1);
    for (int i = 0; i < 300 && nWEDMA; i++) @(negedge CLK);
    checkVal("midrst_write_seen", 32'(nWEDMA), 0);
    nRST = 1'b0;
    @(negedge CLK);
    checkVal("midrst_dma", 32'(DMA), 0);
    checkVal("midrst_nwedma", 32'(nWEDMA), 1);
    checkVal("midrst_busy", 32'(Busy), 0);
    checkVal("midrst_strobes", 32'({RRd, RWr}), 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
